// File: rtl/depth_sequencer.sv
// depth_sequencer: per-frame ball depth sequencer (serve, recede, approach, paddle check).
// Optional speed-up on paddle hits is enabled by defining DEPTH_SEQ_SPEEDUP_EN.
module depth_sequencer #(
    parameter int Z_MAX          = 127,
    parameter int SPEED_INIT     = 2,
    parameter int SPEED_MAX      = 8,
    parameter int SERVE_DELAY    = 60,
    parameter int SPEED_UP_EVERY = 4
) (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic       serve_req,
    input  logic       paddle_hit,
    output logic [9:0] pos_z,
    output logic       dir,
    output logic       ball_active,
    output logic       serve_ack,
    output logic       miss,
    output logic [7:0] hit_count,
    output logic [3:0] speed
);

    localparam int CNT_W = (SERVE_DELAY > 1) ? $clog2(SERVE_DELAY) : 1;

    localparam logic [9:0]       ZMAX_C       = 10'(Z_MAX);
    localparam logic [3:0]       SPEED_INIT_C = 4'(SPEED_INIT);
    localparam logic [CNT_W-1:0] SERVE_LOAD_C = CNT_W'(SERVE_DELAY - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO_C   = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE_C    = CNT_W'(1);

`ifdef DEPTH_SEQ_SPEEDUP_EN
    localparam logic [3:0] SPEED_MAX_C   = 4'(SPEED_MAX);
    localparam logic [7:0] SPEED_EVERY_C = 8'(SPEED_UP_EVERY);
`endif

    // Reject parameter sets the datapath widths cannot represent.
    generate
        if ((Z_MAX < 1) || (Z_MAX > 1023) ||
            (SPEED_INIT < 1) || (SPEED_INIT > 15) ||
            (SPEED_MAX < SPEED_INIT) || (SPEED_MAX > 15) ||
            (SERVE_DELAY < 1) ||
            (SPEED_UP_EVERY < 1) || (SPEED_UP_EVERY > 255)) begin : g_bad_cfg
            $error("depth_sequencer: invalid parameter set");
        end
    endgenerate

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SERVE    = 3'd1,
        ST_RECEDE   = 3'd2,
        ST_APPROACH = 3'd3,
        ST_CHECK    = 3'd4
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [9:0]       pos_z_r;
    logic [9:0]       pos_z_s;
    logic             dir_r;
    logic             dir_s;
    logic             ball_active_r;
    logic             ball_active_s;
    logic             serve_ack_r;
    logic             serve_ack_s;
    logic             miss_r;
    logic             miss_s;
    logic [7:0]       hit_count_r;
    logic [7:0]       hit_count_s;
    logic [3:0]       speed_r;
    logic [3:0]       speed_s;
    logic [CNT_W-1:0] serve_cnt_r;
    logic [CNT_W-1:0] serve_cnt_s;
    logic [10:0]      sum_s;

    // Next-state, next-position and next-output computation.
    always_comb begin
        state_s     = state_r;
        pos_z_s     = pos_z_r;
        serve_ack_s = 1'b0;
        miss_s      = 1'b0;
        hit_count_s = hit_count_r;
        serve_cnt_s = serve_cnt_r;
`ifdef DEPTH_SEQ_SPEEDUP_EN
        speed_s     = speed_r;
`else
        speed_s     = SPEED_INIT_C;
`endif
        // 11-bit sum so a step past the far wall is seen before clamping.
        sum_s       = {1'b0, pos_z_r} + {7'd0, speed_r};

        case (state_r)
            ST_IDLE: begin
                pos_z_s = 10'd0;
                if (serve_req) begin
                    state_s     = ST_SERVE;
                    serve_ack_s = 1'b1;
                    hit_count_s = 8'd0;
                    speed_s     = SPEED_INIT_C;
                    serve_cnt_s = SERVE_LOAD_C;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SERVE: begin
                pos_z_s = 10'd0;
                if (serve_cnt_r == CNT_ZERO_C) begin
                    state_s = ST_RECEDE;
                end else begin
                    serve_cnt_s = serve_cnt_r - CNT_ONE_C;
                end
            end
            ST_RECEDE: begin
                if (sum_s >= {1'b0, ZMAX_C}) begin
                    pos_z_s = ZMAX_C;
                    state_s = ST_APPROACH;
                end else begin
                    pos_z_s = sum_s[9:0];
                end
            end
            ST_APPROACH: begin
                // Borrow check up front: the position never wraps below zero.
                if (pos_z_r <= {6'd0, speed_r}) begin
                    pos_z_s = 10'd0;
                    state_s = ST_CHECK;
                end else begin
                    pos_z_s = pos_z_r - {6'd0, speed_r};
                end
            end
            ST_CHECK: begin
                pos_z_s = 10'd0;
                if (paddle_hit) begin
                    state_s = ST_RECEDE;
                    if (hit_count_r == 8'hFF) begin
                        hit_count_s = 8'hFF;
                    end else begin
                        hit_count_s = hit_count_r + 8'd1;
                    end
`ifdef DEPTH_SEQ_SPEEDUP_EN
                    if ((hit_count_s != 8'd0) && ((hit_count_s % SPEED_EVERY_C) == 8'd0)) begin
                        if (speed_r >= SPEED_MAX_C) begin
                            speed_s = SPEED_MAX_C;
                        end else begin
                            speed_s = speed_r + 4'd1;
                        end
                    end else begin
                        speed_s = speed_r;
                    end
`endif
                end else begin
                    state_s = ST_IDLE;
                    miss_s  = 1'b1;
                end
            end
            default: begin
                state_s = ST_IDLE;
                pos_z_s = 10'd0;
            end
        endcase

        dir_s         = (state_s == ST_RECEDE);
        ball_active_s = (state_s != ST_IDLE);
    end

    // State and registered outputs; Reset clears everything asynchronously.
    always_ff @(posedge frame_clk or negedge Reset) begin
        if (!Reset) begin
            state_r       <= ST_IDLE;
            pos_z_r       <= 10'd0;
            dir_r         <= 1'b0;
            ball_active_r <= 1'b0;
            serve_ack_r   <= 1'b0;
            miss_r        <= 1'b0;
            hit_count_r   <= 8'd0;
            speed_r       <= SPEED_INIT_C;
            serve_cnt_r   <= CNT_ZERO_C;
        end else begin
            state_r       <= state_s;
            pos_z_r       <= pos_z_s;
            dir_r         <= dir_s;
            ball_active_r <= ball_active_s;
            serve_ack_r   <= serve_ack_s;
            miss_r        <= miss_s;
            hit_count_r   <= hit_count_s;
            speed_r       <= speed_s;
            serve_cnt_r   <= serve_cnt_s;
        end
    end

    assign pos_z       = pos_z_r;
    assign dir         = dir_r;
    assign ball_active = ball_active_r;
    assign serve_ack   = serve_ack_r;
    assign miss        = miss_r;
    assign hit_count   = hit_count_r;
    assign speed       = speed_r;

endmodule

// File: tb/tb_depth_sequencer.sv
// Self-checking bench for depth_sequencer: cycle-level scoreboard plus per-scenario checks.
module tb_depth_sequencer;

    localparam int Z_MAX          = 127;
    localparam int SPEED_INIT     = 2;
    localparam int SPEED_MAX      = 8;
    localparam int SERVE_DELAY    = 60;
    localparam int SPEED_UP_EVERY = 4;

`ifdef DEPTH_SEQ_SPEEDUP_EN
    localparam int SPEED_AFTER_4  = 3;
    localparam int SPEED_AFTER_24 = 8;
`else
    localparam int SPEED_AFTER_4  = 2;
    localparam int SPEED_AFTER_24 = 2;
`endif

    logic       frame_clk = 1'b0;
    logic       Reset     = 1'b0;
    logic       serve_req = 1'b0;
    logic       paddle_hit = 1'b0;
    logic [9:0] pos_z;
    logic       dir;
    logic       ball_active;
    logic       serve_ack;
    logic       miss;
    logic [7:0] hit_count;
    logic [3:0] speed;

    depth_sequencer #(
        .Z_MAX(Z_MAX), .SPEED_INIT(SPEED_INIT), .SPEED_MAX(SPEED_MAX),
        .SERVE_DELAY(SERVE_DELAY), .SPEED_UP_EVERY(SPEED_UP_EVERY)
    ) dut (
        .frame_clk(frame_clk), .Reset(Reset), .serve_req(serve_req),
        .paddle_hit(paddle_hit), .pos_z(pos_z), .dir(dir),
        .ball_active(ball_active), .serve_ack(serve_ack), .miss(miss),
        .hit_count(hit_count), .speed(speed)
    );

    always #5 frame_clk = ~frame_clk;

    typedef struct packed {
        logic [9:0] pos;
        logic       dr;
        logic       act;
        logic       ack;
        logic       ms;
        logic [7:0] hit;
        logic [3:0] spd;
    } obs_t;

    obs_t sb_q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;

    // Behavioural reference: 0 IDLE, 1 SERVE, 2 RECEDE, 3 APPROACH, 4 CHECK
    int   m_state, m_pos, m_cnt, m_hit, m_speed;
    logic m_ack, m_miss;

    task automatic model_reset();
        m_state = 0; m_pos = 0; m_cnt = 0; m_hit = 0; m_speed = SPEED_INIT;
        m_ack = 1'b0; m_miss = 1'b0;
        sb_q.delete();
    endtask

    task automatic model_step(input logic sr, input logic ph);
        m_ack = 1'b0;
        m_miss = 1'b0;
        case (m_state)
            0: if (sr) begin
                m_state = 1; m_ack = 1'b1; m_hit = 0; m_speed = SPEED_INIT; m_cnt = SERVE_DELAY - 1;
            end
            1: if (m_cnt == 0) m_state = 2; else m_cnt = m_cnt - 1;
            2: begin
                m_pos = m_pos + m_speed;
                if (m_pos >= Z_MAX) begin m_pos = Z_MAX; m_state = 3; end
            end
            3: begin
                m_pos = m_pos - m_speed;
                if (m_pos <= 0) begin m_pos = 0; m_state = 4; end
            end
            4: if (ph) begin
                if (m_hit < 255) m_hit = m_hit + 1;
                m_state = 2;
`ifdef DEPTH_SEQ_SPEEDUP_EN
                if ((m_hit % SPEED_UP_EVERY) == 0 && m_hit != 0 && m_speed < SPEED_MAX)
                    m_speed = m_speed + 1;
`endif
            end else begin
                m_state = 0; m_miss = 1'b1;
            end
            default: m_state = 0;
        endcase
    endtask

    function automatic obs_t model_out();
        obs_t o;
        o.pos = 10'(m_pos);
        o.dr  = (m_state == 2);
        o.act = (m_state != 0);
        o.ack = m_ack;
        o.ms  = m_miss;
        o.hit = 8'(m_hit);
        o.spd = 4'(m_speed);
        return o;
    endfunction

    // Drive one frame: push the expected outputs, clock, then pop and compare.
    task automatic cycle(input logic sr, input logic ph);
        obs_t e;
        obs_t a;
        serve_req  = sr;
        paddle_hit = ph;
        model_step(sr, ph);
        sb_q.push_back(model_out());
        @(posedge frame_clk);
        #1;
        cyc++;
        e = sb_q.pop_front();
        a = '{pos: pos_z, dr: dir, act: ball_active, ack: serve_ack, ms: miss, hit: hit_count, spd: speed};
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL scoreboard cycle %0d: got pos=%0d dir=%0b act=%0b ack=%0b miss=%0b hit=%0d spd=%0d, want pos=%0d dir=%0b act=%0b ack=%0b miss=%0b hit=%0d spd=%0d",
                     cyc, a.pos, a.dr, a.act, a.ack, a.ms, a.hit, a.spd,
                     e.pos, e.dr, e.act, e.ack, e.ms, e.hit, e.spd);
        end
    endtask

    task automatic run_to_check();
        int guard = 0;
        while (m_state != 4 && guard < 400) begin
            cycle(1'b0, 1'b0);
            guard++;
        end
        total++;
        if (m_state != 4) begin
            bad++;
            $display("FAIL run_to_check: no CHECK within %0d cycles, model state=%0d", guard, m_state);
        end
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            serve_req = ~serve_req;
            @(posedge frame_clk);
            #1;
            total++;
            if ({pos_z, dir, ball_active, serve_ack, miss, hit_count, speed} !==
                {10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 4'(SPEED_INIT)}) begin
                bad++;
                $display("FAIL reset_hold: got pos=%0d dir=%0b act=%0b ack=%0b miss=%0b hit=%0d spd=%0d, want all zero spd=%0d",
                         pos_z, dir, ball_active, serve_ack, miss, hit_count, speed, SPEED_INIT);
            end
        end
        Reset = 1'b1;
        model_reset();
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0);
        total++;
        if (pos_z !== 10'd0 || ball_active !== 1'b0) begin
            bad++;
            $display("FAIL idle_after_reset: got pos=%0d act=%0b, want 0 0", pos_z, ball_active);
        end
    endtask

    task automatic test_serve_recede();
        int nz = 0;
        int exp_pos;
        cycle(1'b1, 1'b0);
        total++;
        if (serve_ack !== 1'b1) begin
            bad++;
            $display("FAIL serve_ack_pulse: got %0b want 1", serve_ack);
        end
        cycle(1'b0, 1'b0);
        total++;
        if (serve_ack !== 1'b0) begin
            bad++;
            $display("FAIL serve_ack_width: got %0b want 0", serve_ack);
        end
        for (int i = 0; i < SERVE_DELAY - 1; i++) begin
            cycle(1'b0, 1'b0);
            if (pos_z !== 10'd0) nz++;
        end
        total++;
        if (nz != 0) begin
            bad++;
            $display("FAIL serve_hold: %0d serve cycles had nonzero pos_z, want 0", nz);
        end
        for (int k = 1; k <= 64; k++) begin
            exp_pos = (2 * k > Z_MAX) ? Z_MAX : 2 * k;
            cycle(k == 10, 1'b0);
            total++;
            if (pos_z !== 10'(exp_pos) || dir !== (k < 64)) begin
                bad++;
                $display("FAIL recede_step %0d: got pos=%0d dir=%0b want pos=%0d dir=%0b", k, pos_z, dir, exp_pos, (k < 64));
            end
            if (k == 10) begin
                total++;
                if (serve_ack !== 1'b0) begin
                    bad++;
                    $display("FAIL serve_ignored: got ack=%0b want 0", serve_ack);
                end
            end
        end
    endtask

    task automatic test_approach_miss();
        int exp_pos;
        for (int k = 1; k <= 64; k++) begin
            exp_pos = (Z_MAX - 2 * k < 0) ? 0 : Z_MAX - 2 * k;
            cycle(1'b0, (k >= 20 && k <= 30));
            total++;
            if (pos_z !== 10'(exp_pos) || dir !== 1'b0) begin
                bad++;
                $display("FAIL approach_step %0d: got pos=%0d dir=%0b want pos=%0d dir=0", k, pos_z, dir, exp_pos);
            end
        end
        total++;
        if (ball_active !== 1'b1 || miss !== 1'b0 || hit_count !== 8'd0) begin
            bad++;
            $display("FAIL check_state: got act=%0b miss=%0b hit=%0d want 1 0 0", ball_active, miss, hit_count);
        end
        cycle(1'b0, 1'b0);
        total++;
        if (miss !== 1'b1 || ball_active !== 1'b0 || pos_z !== 10'd0) begin
            bad++;
            $display("FAIL miss_pulse: got miss=%0b act=%0b pos=%0d want 1 0 0", miss, ball_active, pos_z);
        end
        cycle(1'b0, 1'b0);
        total++;
        if (miss !== 1'b0) begin
            bad++;
            $display("FAIL miss_width: got %0b want 0", miss);
        end
    endtask

    task automatic test_hits();
        int exp_hit;
        cycle(1'b1, 1'b0);
        for (int h = 1; h <= 300; h++) begin
            run_to_check();
            cycle(1'b0, 1'b1);
            exp_hit = (h > 255) ? 255 : h;
            total++;
            if (hit_count !== 8'(exp_hit) || pos_z !== 10'd0 || dir !== 1'b1) begin
                bad++;
                $display("FAIL hit_%0d: got hit=%0d pos=%0d dir=%0b want hit=%0d pos=0 dir=1", h, hit_count, pos_z, dir, exp_hit);
            end
            if (h == 3 || h == 4 || h == 24) begin
                total++;
                if (speed !== 4'((h == 3) ? SPEED_INIT : (h == 4) ? SPEED_AFTER_4 : SPEED_AFTER_24)) begin
                    bad++;
                    $display("FAIL speed_after_%0d: got %0d want %0d", h, speed,
                             (h == 3) ? SPEED_INIT : (h == 4) ? SPEED_AFTER_4 : SPEED_AFTER_24);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        run_to_check();
        cycle(1'b1, 1'b0);
        total++;
        if (miss !== 1'b1 || serve_ack !== 1'b0 || hit_count !== 8'd255) begin
            bad++;
            $display("FAIL miss_with_serve: got miss=%0b ack=%0b hit=%0d want 1 0 255", miss, serve_ack, hit_count);
        end
        cycle(1'b1, 1'b0);
        total++;
        if (serve_ack !== 1'b1 || hit_count !== 8'd0 || speed !== 4'(SPEED_INIT)) begin
            bad++;
            $display("FAIL reserve: got ack=%0b hit=%0d spd=%0d want 1 0 %0d", serve_ack, hit_count, speed, SPEED_INIT);
        end
    endtask

    task automatic test_reset_mid();
        int guard = 0;
        while (!(m_state == 2 && m_pos == 64) && guard < 400) begin
            cycle(1'b0, 1'b0);
            guard++;
        end
        total++;
        if (pos_z !== 10'd64) begin
            bad++;
            $display("FAIL reach_64: got pos=%0d want 64", pos_z);
        end
        #2;
        Reset = 1'b0;
        #1;
        total++;
        if ({pos_z, dir, ball_active, serve_ack, miss, hit_count, speed} !==
            {10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 4'(SPEED_INIT)}) begin
            bad++;
            $display("FAIL async_reset: got pos=%0d dir=%0b act=%0b ack=%0b miss=%0b hit=%0d spd=%0d, want all zero spd=%0d",
                     pos_z, dir, ball_active, serve_ack, miss, hit_count, speed, SPEED_INIT);
        end
        model_reset();
        @(posedge frame_clk);
        #1;
        Reset = 1'b1;
        cycle(1'b0, 1'b0);
        cycle(1'b1, 1'b0);
        total++;
        if (serve_ack !== 1'b1 || hit_count !== 8'd0 || ball_active !== 1'b1) begin
            bad++;
            $display("FAIL fresh_serve: got ack=%0b hit=%0d act=%0b want 1 0 1", serve_ack, hit_count, ball_active);
        end
        for (int i = 0; i < SERVE_DELAY + 4; i++) cycle(1'b0, 1'b0);
    endtask

    initial begin
        model_reset();
        test_reset();
        test_serve_recede();
        test_approach_miss();
        test_hits();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/depth_sequencer.md
# depth_sequencer

Per-frame controller that sequences the ball's depth coordinate `pos_z` for the depth-scaled cursor/ball renderer. It owns the serve handshake, steps the ball from the near plane to the far wall and back once per `frame_clk`, and checks the paddle hit at the near plane. It also counts rallies and optionally raises ball speed. The block sits between game input logic and the cursor drawing logic, which consumes `pos_z` directly.

## Interface
- `Z_MAX`, 127: far-wall depth; `pos_z` range is 0..Z_MAX.
- `SPEED_INIT`, 2: depth step per frame after a serve (1..15).
- `SPEED_MAX`, 8: speed ceiling (≥ SPEED_INIT, ≤ 15).
- `SERVE_DELAY`, 60: frames spent in SERVE before motion (≥ 1).
- `SPEED_UP_EVERY`, 4: hits per speed increment (≥ 1).

- `frame_clk`  in  1  sole clock; one rising edge per video frame.
- `Reset`  in  1  asynchronous, active-low reset.
- `serve_req`  in  1  level request to start a ball; honoured only in IDLE.
- `paddle_hit`  in  1  paddle overlaps ball footprint; sampled only in CHECK.
- `pos_z`  out  10  ball depth, registered; 0 = near plane.
- `dir`  out  1  1 = receding (RECEDE), 0 otherwise.
- `ball_active`  out  1  high in SERVE/RECEDE/APPROACH/CHECK.
- `serve_ack`  out  1  one-cycle pulse on entry to SERVE.
- `miss`  out  1  one-cycle pulse on CHECK→IDLE.
- `hit_count`  out  8  rally hit counter, saturates at 255.
- `speed`  out  4  current depth step.

## Operation
- All outputs are registered. While `Reset`=0: state IDLE, `pos_z`=0, `dir`=0, `ball_active`=0, `serve_ack`=0, `miss`=0, `hit_count`=0, `speed`=SPEED_INIT, serve counter=0.
- IDLE: `pos_z` holds 0. `serve_req`=1 at an edge → SERVE. On that edge `serve_ack`←1, `hit_count`←0, `speed`←SPEED_INIT, and the serve counter←SERVE_DELAY−1.
- SERVE: `pos_z`=0. The counter decrements each edge. At an edge where the counter = 0 → RECEDE. SERVE therefore lasts exactly SERVE_DELAY cycles.
- RECEDE: `pos_z` ← min(`pos_z`+`speed`, Z_MAX). The sum is computed 11 bits wide, then clamped. On the edge where `pos_z` becomes Z_MAX, state → APPROACH.
- APPROACH: `pos_z` ← max(`pos_z`−`speed`, 0). The compare is signed or borrow-checked; it never wraps. On the edge where `pos_z` becomes 0, state → CHECK.
- CHECK, exactly one cycle, `pos_z` holds 0:
  - `paddle_hit`=1 → RECEDE, with `hit_count` ← sat(`hit_count`+1).
  - `paddle_hit`=0 → IDLE, with `miss`←1 for one cycle and `ball_active`←0.
- `serve_req` outside IDLE is ignored; there is no queueing. A `serve_req` held high through a miss re-serves on the first IDLE edge.
- `paddle_hit` outside CHECK has no effect.
- `Reset` asserted mid-rally clears all state immediately, asynchronously. Operation resumes from IDLE on the first edge after release.

## Timing
- `serve_req` sampled at edge N → `serve_ack`=1 during cycle N..N+1. The first nonzero `pos_z` appears after edge N+SERVE_DELAY+1.
- Each RECEDE/APPROACH cycle changes `pos_z` by exactly `speed`, except the final clamped step.
- Leg duration, in either direction: ceil(Z_MAX/`speed`) cycles.
- The CHECK decision takes effect at the following edge. A hit gives a 1-cycle dwell at `pos_z`=0 before the next recede step.
- `dir` and `ball_active` change on the same edge as the state.

## Configuration
- `DEPTH_SEQ_SPEEDUP_EN` defined: on the CHECK→RECEDE edge, if the new `hit_count` is a nonzero multiple of SPEED_UP_EVERY, then `speed` ← min(`speed`+1, SPEED_MAX). The new speed applies from the first RECEDE step.
- `DEPTH_SEQ_SPEEDUP_EN` undefined: `speed` is constant at SPEED_INIT, and the SPEED_MAX/SPEED_UP_EVERY logic is absent.

## Test plan
- Reset values: hold `Reset`=0, toggle clock and `serve_req` → all outputs stay at their reset values. Release, with `serve_req`=0 → IDLE persists, `pos_z`=0.
- Serve and recede: defaults, pulse `serve_req` → `serve_ack` for 1 cycle. `pos_z`=0 for 60 cycles, then 2, 4, … 126, 127 (64 steps) with `dir`=1, then `dir`=0.
- Approach and miss: continue with `paddle_hit`=0 → `pos_z` 125 … 1, 0 (64 steps). CHECK for 1 cycle, then `miss` pulse, `ball_active`=0, IDLE.
- Hit and speed-up: with the macro defined, assert `paddle_hit` at every CHECK → `hit_count` 1..4. `speed` becomes 3 after the 4th hit and caps at 8 after 24 hits. Without the macro, `speed` stays 2.
- Ignored and edge inputs: `serve_req` pulsed during RECEDE → no `serve_ack`. `paddle_hit` during APPROACH → no effect. `hit_count` saturates at 255 after 300 hits.
- Reset mid-rally: assert `Reset` at `pos_z`=64 → all outputs return to reset values without waiting for a clock edge. The next serve starts a fresh rally with `hit_count`=0.
